// File: rtl/alu_writeback.sv
`default_nettype none
// ============================================================================
//  Module   : alu_writeback
//  Purpose  : ALU writeback stage: 2-entry result queue draining into the
//             register-file write port, BEQ branch pulse and zero flag.
//             Optional macro ALU_WB_CARRY_EN adds the carry-word second write.
//  Revision : 1.0  initial release
// ============================================================================
module alu_writeback #(
    parameter int reg_width  = 8,
    parameter int op_width   = 4,
    parameter int addr_width = 4,
    parameter int carry_addr = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [op_width-1:0]   in_op,
    input  logic [addr_width-1:0] in_dest,
    input  logic [reg_width-1:0]  in_res,
    input  logic [reg_width-1:0]  in_car,
    input  logic                  in_zero,
    input  logic                  in_jump,
    output logic                  rf_we,
    output logic [addr_width-1:0] rf_waddr,
    output logic [reg_width-1:0]  rf_wdata,
    output logic                  branch_taken,
    output logic                  zero_flag,
    output logic                  busy
);

    localparam logic [addr_width-1:0] c_carry_addr = addr_width'(carry_addr);

    typedef struct packed {
        logic [op_width-1:0]   op;
        logic [addr_width-1:0] dest;
        logic [reg_width-1:0]  res;
`ifdef ALU_WB_CARRY_EN
        logic [reg_width-1:0]  car;
`endif
        logic                  zero;
        logic                  jump;
    } entry_t;

    entry_t                r_mem [2];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_count;
    logic                  r_rf_we;
    logic [addr_width-1:0] r_rf_waddr;
    logic [reg_width-1:0]  r_rf_wdata;
    logic                  r_branch;
    logic                  r_zero;

    entry_t                w_in_entry;
    entry_t                w_head;
    logic [31:0]           w_op_num;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_is_result;
    logic                  w_is_beq;

`ifdef ALU_WB_CARRY_EN
    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CARRY = 1'b1
    } state_t;

    state_t                r_state;
    logic [reg_width-1:0]  r_car;
    logic                  w_is_carry;

    assign w_pop = (r_count != 2'd0) && (r_state == S_IDLE);
    assign busy  = (r_count != 2'd0) || (r_state == S_CARRY);
`else
    logic                  w_unused_car;

    assign w_unused_car = ^in_car;
    assign w_pop        = (r_count != 2'd0);
    assign busy         = (r_count != 2'd0);
`endif

    // Readiness looks only at registered occupancy: a full queue refuses a
    // push even when the head is popped in the same cycle.
    assign in_ready = (r_count != 2'd2);
    assign w_push   = in_valid && in_ready;
    assign w_head   = r_mem[r_rd_ptr];
    assign w_op_num = 32'(w_head.op);

    always_comb begin
        w_in_entry      = '0;
        w_in_entry.op   = in_op;
        w_in_entry.dest = in_dest;
        w_in_entry.res  = in_res;
`ifdef ALU_WB_CARRY_EN
        w_in_entry.car  = in_car;
`endif
        w_in_entry.zero = in_zero;
        w_in_entry.jump = in_jump;
    end

    always_comb begin
        w_is_result = 1'b0;
        w_is_beq    = 1'b0;
`ifdef ALU_WB_CARRY_EN
        w_is_carry  = 1'b0;
`endif
        case (w_op_num)
            32'd0, 32'd1, 32'd2, 32'd3, 32'd6: w_is_result = 1'b1;
`ifdef ALU_WB_CARRY_EN
            32'd4, 32'd5, 32'd8, 32'd9, 32'd10: w_is_carry = 1'b1;
`else
            32'd4, 32'd5, 32'd8, 32'd9, 32'd10: w_is_result = 1'b1;
`endif
            32'd7:   w_is_beq = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_in_entry;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
            r_branch   <= 1'b0;
            r_zero     <= 1'b0;
`ifdef ALU_WB_CARRY_EN
            r_state    <= S_IDLE;
            r_car      <= '0;
`endif
        end else begin
            r_rf_we  <= 1'b0;
            r_branch <= 1'b0;

            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: ;
            endcase

`ifdef ALU_WB_CARRY_EN
            // Carry word lands after the result, so it wins when dest == carry_addr.
            if (r_state == S_CARRY) begin
                r_rf_we    <= 1'b1;
                r_rf_waddr <= c_carry_addr;
                r_rf_wdata <= r_car;
                r_state    <= S_IDLE;
            end else
`endif
            if (w_pop) begin
`ifdef ALU_WB_CARRY_EN
                if (w_is_result || w_is_carry) begin
`else
                if (w_is_result) begin
`endif
                    r_rf_we    <= 1'b1;
                    r_rf_waddr <= w_head.dest;
                    r_rf_wdata <= w_head.res;
                    r_zero     <= w_head.zero;
                end
                if (w_is_beq) begin
                    r_branch <= w_head.jump;
                end
`ifdef ALU_WB_CARRY_EN
                if (w_is_carry) begin
                    r_state <= S_CARRY;
                    r_car   <= w_head.car;
                end
`endif
            end
        end
    end

    assign rf_we        = r_rf_we;
    assign rf_waddr     = r_rf_waddr;
    assign rf_wdata     = r_rf_wdata;
    assign branch_taken = r_branch;
    assign zero_flag    = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_alu_writeback.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_writeback
//  Purpose  : Directed vector table plus hand sequences for alu_writeback.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_writeback;

    localparam int RW = 8;
    localparam int OW = 4;
    localparam int AW = 4;
    localparam int CA = 1;
`ifdef ALU_WB_CARRY_EN
    localparam bit CEN = 1'b1;
`else
    localparam bit CEN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [OW-1:0] in_op;
    logic [AW-1:0] in_dest;
    logic [RW-1:0] in_res;
    logic [RW-1:0] in_car;
    logic          in_zero;
    logic          in_jump;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [RW-1:0] rf_wdata;
    logic          branch_taken;
    logic          zero_flag;
    logic          busy;

    always #5 clk = ~clk;

    alu_writeback #(
        .reg_width (RW),
        .op_width  (OW),
        .addr_width(AW),
        .carry_addr(CA)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_dest     (in_dest),
        .in_res      (in_res),
        .in_car      (in_car),
        .in_zero     (in_zero),
        .in_jump     (in_jump),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .branch_taken(branch_taken),
        .zero_flag   (zero_flag),
        .busy        (busy)
    );

    typedef struct {
        logic [3:0] op;
        logic [3:0] dest;
        logic [7:0] res;
        logic [7:0] car;
        logic       zero;
        logic       jump;
        logic       carry;
        logic       exp_we;
        logic [3:0] exp_waddr;
        logic [7:0] exp_wdata;
        logic       exp_br;
        logic       exp_zf;
    } vec_t;

    vec_t       vecs [10];
    int         checks = 0;
    int         errors = 0;
    logic [3:0] last_addr = '0;
    logic [7:0] last_data = '0;
    logic [11:0] seq [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [3:0] dest, input logic [7:0] res,
                         input logic [7:0] car, input logic zero, input logic jump);
        in_valid = 1'b1;
        in_op    = op;
        in_dest  = dest;
        in_res   = res;
        in_car   = car;
        in_zero  = zero;
        in_jump  = jump;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            op  dest res    car    z  j  cy we waddr wdata br zf
        vecs[0] = '{4'd0,  4'd3,  8'hA5, 8'h00, 0, 0, 0, 1, 4'd3,  8'hA5, 0, 0};
        vecs[1] = '{4'd6,  4'd7,  8'h00, 8'h00, 1, 0, 0, 1, 4'd7,  8'h00, 0, 1};
        vecs[2] = '{4'd7,  4'd9,  8'h55, 8'h00, 0, 1, 0, 0, 4'd0,  8'h00, 1, 1};
        vecs[3] = '{4'd7,  4'd9,  8'h56, 8'h00, 0, 0, 0, 0, 4'd0,  8'h00, 0, 1};
        vecs[4] = '{4'd12, 4'd4,  8'h33, 8'h00, 0, 1, 0, 0, 4'd0,  8'h00, 0, 1};
        vecs[5] = '{4'd4,  4'd2,  8'h00, 8'h01, 1, 0, 1, 1, 4'd2,  8'h00, 0, 1};
        vecs[6] = '{4'd8,  4'd5,  8'h40, 8'h77, 0, 0, 1, 1, 4'd5,  8'h40, 0, 0};
        vecs[7] = '{4'd3,  4'd15, 8'hFF, 8'h00, 0, 0, 0, 1, 4'd15, 8'hFF, 0, 0};
        vecs[8] = '{4'd10, 4'd1,  8'h12, 8'h34, 1, 0, 1, 1, 4'd1,  8'h12, 0, 1};
        vecs[9] = '{4'd15, 4'd6,  8'h21, 8'h43, 0, 1, 0, 0, 4'd0,  8'h00, 0, 1};

        reset = 1'b1;
        drive(4'd0, 4'd0, 8'h00, 8'h00, 1'b0, 1'b0);
        in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;

        chk("reset_we",    32'(rf_we),        32'd0);
        chk("reset_waddr", 32'(rf_waddr),     32'd0);
        chk("reset_wdata", 32'(rf_wdata),     32'd0);
        chk("reset_br",    32'(branch_taken), 32'd0);
        chk("reset_zf",    32'(zero_flag),    32'd0);
        chk("reset_busy",  32'(busy),         32'd0);
        chk("reset_ready", 32'(in_ready),     32'd1);

        // Single-entry vectors, each into an empty queue.
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].op, vecs[i].dest, vecs[i].res, vecs[i].car, vecs[i].zero, vecs[i].jump);
            tick();
            in_valid = 1'b0;
            chk($sformatf("v%0d_nobypass_we", i), 32'(rf_we), 32'd0);
            chk($sformatf("v%0d_busy_queued", i), 32'(busy),  32'd1);
            tick();
            chk($sformatf("v%0d_we", i), 32'(rf_we),        32'(vecs[i].exp_we));
            chk($sformatf("v%0d_br", i), 32'(branch_taken), 32'(vecs[i].exp_br));
            chk($sformatf("v%0d_zf", i), 32'(zero_flag),    32'(vecs[i].exp_zf));
            if (vecs[i].exp_we) begin
                last_addr = vecs[i].exp_waddr;
                last_data = vecs[i].exp_wdata;
            end
            chk($sformatf("v%0d_waddr", i), 32'(rf_waddr), 32'(last_addr));
            chk($sformatf("v%0d_wdata", i), 32'(rf_wdata), 32'(last_data));
            if (vecs[i].carry && CEN) begin
                chk($sformatf("v%0d_busy_carry", i), 32'(busy), 32'd1);
                tick();
                last_addr = 4'(CA);
                last_data = vecs[i].car;
                chk($sformatf("v%0d_cwe", i),   32'(rf_we),        32'd1);
                chk($sformatf("v%0d_caddr", i), 32'(rf_waddr),     32'(last_addr));
                chk($sformatf("v%0d_cdata", i), 32'(rf_wdata),     32'(last_data));
                chk($sformatf("v%0d_czf", i),   32'(zero_flag),    32'(vecs[i].exp_zf));
                chk($sformatf("v%0d_cbr", i),   32'(branch_taken), 32'd0);
            end
            chk($sformatf("v%0d_busy_done", i), 32'(busy), 32'd0);
            tick();
            chk($sformatf("v%0d_idle_we", i), 32'(rf_we),        32'd0);
            chk($sformatf("v%0d_idle_br", i), 32'(branch_taken), 32'd0);
        end

        // Three back-to-back op-5 entries.
        if (CEN) begin
            seq.push_back({4'd2, 8'h10}); seq.push_back({4'd1, 8'h20});
            seq.push_back({4'd3, 8'h11}); seq.push_back({4'd1, 8'h21});
            seq.push_back({4'd4, 8'h12}); seq.push_back({4'd1, 8'h22});
        end else begin
            seq.push_back({4'd2, 8'h10});
            seq.push_back({4'd3, 8'h11});
            seq.push_back({4'd4, 8'h12});
        end
        drive(4'd5, 4'd2, 8'h10, 8'h20, 1'b0, 1'b0);
        chk("b2b_ready0", 32'(in_ready), 32'd1);
        tick();
        drive(4'd5, 4'd3, 8'h11, 8'h21, 1'b0, 1'b0);
        chk("b2b_ready1", 32'(in_ready), 32'd1);
        tick();
        drive(4'd5, 4'd4, 8'h12, 8'h22, 1'b0, 1'b0);
        chk("b2b_ready2", 32'(in_ready), 32'd1);
        chk("b2b_w0_we",    32'(rf_we),    32'd1);
        chk("b2b_w0_addr",  32'(rf_waddr), 32'(seq[0][11:8]));
        chk("b2b_w0_data",  32'(rf_wdata), 32'(seq[0][7:0]));
        tick();
        in_valid = 1'b0;
        chk("b2b_ready_full", 32'(in_ready), CEN ? 32'd0 : 32'd1);
        for (int k = 1; k < seq.size(); k++) begin
            chk($sformatf("b2b_w%0d_we", k),   32'(rf_we),    32'd1);
            chk($sformatf("b2b_w%0d_addr", k), 32'(rf_waddr), 32'(seq[k][11:8]));
            chk($sformatf("b2b_w%0d_data", k), 32'(rf_wdata), 32'(seq[k][7:0]));
            tick();
        end
        chk("b2b_end_we",   32'(rf_we), 32'd0);
        chk("b2b_end_busy", 32'(busy),  32'd0);

        // Reset while draining: with carry enabled the FSM is in CARRY here.
        drive(4'd4, 4'd6, 8'h99, 8'h88, 1'b0, 1'b0);
        tick();
        drive(4'd0, 4'd7, 8'h66, 8'h00, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        chk("rst_mid_we_before", 32'(rf_we),    32'd1);
        chk("rst_mid_busy_before", 32'(busy),   32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid_we",    32'(rf_we),        32'd0);
        chk("rst_mid_waddr", 32'(rf_waddr),     32'd0);
        chk("rst_mid_wdata", 32'(rf_wdata),     32'd0);
        chk("rst_mid_busy",  32'(busy),         32'd0);
        chk("rst_mid_ready", 32'(in_ready),     32'd1);
        chk("rst_mid_br",    32'(branch_taken), 32'd0);
        tick();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("rst_after%0d_we", k),   32'(rf_we), 32'd0);
            chk($sformatf("rst_after%0d_busy", k), 32'(busy),  32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
